// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between a writer and a reader with
// round-robin bounded-burst arbitration, plus a whole-RAM zero-fill sequencer.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_init,
  output logic                  o_init_busy,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_gnt,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_gnt,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_wren,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic {ARB, INIT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d, addr_q, addr_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  last_wr_q, last_wr_d, rd_valid_q, rd_valid_d;
  logic                  arb, keep, gnt;
  always_comb begin
    arb = state_q == ARB;
    // The owner may keep the port only while it has burst budget left; an exhausted
    // or absent owner hands a contested cycle to whoever did not go last.
    keep = burst_q != '0 && burst_q < BW'(BURST_LEN);
    o_wr_gnt = arb && i_wr_req && (!i_rd_req || (keep ? last_wr_q : !last_wr_q));
    o_rd_gnt = arb && i_rd_req && !o_wr_gnt;
    gnt = o_wr_gnt || o_rd_gnt;
    o_ram_wren = !arb || o_wr_gnt;
    o_ram_addr = !arb ? init_cnt_q : o_wr_gnt ? i_wr_addr : o_rd_gnt ? i_rd_addr : addr_q;
    o_ram_data = o_wr_gnt ? i_wr_data : '0;
    addr_d = gnt ? o_ram_addr : addr_q;
    last_wr_d = gnt ? o_wr_gnt : last_wr_q;
    burst_d = !gnt ? '0 : (o_wr_gnt != last_wr_q || burst_q == '0) ? BW'(1) : keep ? burst_q + 1'b1 : burst_q;
    state_d = arb ? (i_init ? INIT : ARB) : (&init_cnt_q ? ARB : INIT);
    init_cnt_d = arb ? '0 : init_cnt_q + 1'b1;
    // A read granted on the edge that enters INIT is dropped.
    rd_valid_d = o_rd_gnt && !i_init;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q    <= ARB;
      init_cnt_q <= '0;
      addr_q     <= '0;
      burst_q    <= '0;
      last_wr_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      last_wr_q  <= last_wr_d;
      rd_valid_q <= rd_valid_d;
    end
  assign o_init_busy = state_q == INIT;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = i_ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random and directed traffic against a behavioural arbiter/RAM
// model; read data is scoreboarded through a queue checked by an independent monitor.
module tb_ram_port_arbiter;
  localparam int BL = 4;
  logic       clk, rst_n, i_init, busy;
  logic       wr_req, wr_gnt, rd_req, rd_gnt, rd_valid, ram_wren;
  logic [5:0] wr_addr, rd_addr, ram_addr;
  logic [7:0] wr_data, rd_data, ram_data, ram_rdata;
  int total = 0, bad = 0;
  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .BURST_LEN(BL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(i_init), .o_init_busy(busy),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(wr_gnt),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_wren(ram_wren),
    .i_ram_rdata(ram_rdata));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Single-port RAM with registered read address: a write is visible to the next read.
  logic [7:0] mem [64];
  logic [5:0] raddr;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    raddr <= ram_addr;
  end
  assign ram_rdata = mem[raddr];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Reference model: who should own each cycle, what the RAM should hold, and the read data due.
  logic [7:0] ref_mem [64];
  logic [7:0] q[$];
  bit         m_init, m_last_wr, m_rdv, ew, er;
  int         m_cnt, m_burst;
  logic [5:0] m_addr, ea;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_init = 0; m_cnt = 0; m_burst = 0; m_last_wr = 0; m_addr = '0; m_rdv = 0;
      q.delete();
    end else begin
      ew = 0; er = 0;
      if (!m_init) begin
        if (wr_req && rd_req) begin
          ew = (m_burst > 0 && m_burst < BL) ? m_last_wr : !m_last_wr;
          er = !ew;
        end else begin
          ew = wr_req; er = rd_req;
        end
      end
      ea = m_init ? 6'(m_cnt) : ew ? wr_addr : er ? rd_addr : m_addr;
      chk("wr_gnt", wr_gnt, ew);
      chk("rd_gnt", rd_gnt, er);
      chk("ram_wren", ram_wren, m_init || ew);
      chk("ram_addr", ram_addr, ea);
      chk("ram_data", ram_data, ew ? wr_data : 8'h00);
      chk("init_busy", busy, m_init);
      chk("rd_valid", rd_valid, m_rdv);
      m_rdv = 0;
      if (m_init) begin
        ref_mem[m_cnt] = 8'h00;
        if (m_cnt == 63) m_init = 0;
        m_cnt++;
        m_burst = 0;
      end else begin
        if (ew || er) begin
          m_burst = (ew == m_last_wr && m_burst > 0) ? (m_burst < BL ? m_burst + 1 : BL) : 1;
          m_last_wr = ew;
          m_addr = ea;
        end else m_burst = 0;
        if (ew) ref_mem[wr_addr] = wr_data;
        if (er && !i_init) begin
          q.push_back(ref_mem[rd_addr]);
          m_rdv = 1;
        end
        if (i_init) begin m_init = 1; m_cnt = 0; end
      end
    end
  end
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && rd_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_extra: valid=1 data=%0h with no read outstanding", rd_data);
      end else begin
        e = q.pop_front();
        chk("rd_data", rd_data, e);
      end
    end
  end
  task automatic xfer(input bit w, input logic [5:0] a, input logic [7:0] d);
    bit g = 0;
    if (w) begin wr_req = 1; wr_addr = a; wr_data = d; end
    else begin rd_req = 1; rd_addr = a; end
    for (int n = 0; n < 200 && !g; n++) begin
      @(negedge clk); g = w ? wr_gnt : rd_gnt;
      @(posedge clk); #1;
    end
    total++;
    if (!g) begin bad++; $display("FAIL grant_timeout: w=%0d addr=%0h got no grant required grant", w, a); end
    if (w) wr_req = 0; else rd_req = 0;
  endtask
  task automatic cycle(input int pw, input int pr, input bit ini);
    bit wg, rg;
    i_init = ini;
    @(negedge clk); wg = wr_gnt; rg = rd_gnt;
    @(posedge clk); #1;
    i_init = 0;
    if (!wr_req || wg) begin
      wr_req = $urandom_range(99) < pw; wr_addr = 6'($urandom_range(63)); wr_data = 8'($urandom_range(255));
    end
    if (!rd_req || rg) begin
      rd_req = $urandom_range(99) < pr; rd_addr = 6'($urandom_range(63));
    end
  endtask
  task automatic wait_init();
    int c = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (busy) c++;
      else if (c > 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("init_len", c, 64);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  initial begin
    rst_n = 0; i_init = 0; wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_gnt", wr_gnt, 0); chk("rst_rd_gnt", rd_gnt, 0); chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_addr, 0); chk("rst_data", ram_data, 0);
    chk("rst_busy", busy, 0); chk("rst_rd_valid", rd_valid, 0);
    rst_n = 1;
    idle(2);
    cycle(0, 0, 1);
    wait_init();
    xfer(0, 6'd0, 8'h0); xfer(0, 6'd17, 8'h0); xfer(0, 6'd63, 8'h0);
    idle(3);
    chk("sb_empty_init", q.size(), 0);
    do_reset();
    wr_req = 1; wr_addr = 6'd40; wr_data = 8'h11; rd_req = 1; rd_addr = 6'd41;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("burst_pat%0d", i), {wr_gnt, rd_gnt}, (i % 8) < 4 ? 2'b10 : 2'b01);
      @(posedge clk); #1;
    end
    wr_req = 0; rd_req = 0;
    idle(3);
    for (int i = 0; i < 10; i++) xfer(1, 6'(5 + i), 8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) xfer(0, 6'(5 + i), 8'h0);
    xfer(1, 6'd9, 8'h5C);
    xfer(0, 6'd9, 8'h0);
    idle(3);
    chk("sb_empty_wr", q.size(), 0);
    wr_req = 1; rd_req = 1; wr_addr = 6'd50; wr_data = 8'h77; rd_addr = 6'd9;
    repeat (3) cycle(100, 100, 0);
    cycle(100, 100, 1);
    wait_init();
    repeat (10) cycle(100, 100, 0);
    repeat (10) cycle(0, 0, 0);
    idle(3);
    chk("sb_empty_both", q.size(), 0);
    repeat (400) cycle(60, 60, $urandom_range(199) == 0);
    repeat (90) cycle(0, 0, 0);
    idle(3);
    chk("sb_empty_rand", q.size(), 0);
    for (int i = 0; i <= 20; i++) xfer(1, 6'(i), 8'(8'hE0 + i));
    xfer(1, 6'd30, 8'h33);
    i_init = 1;
    @(posedge clk); #1;
    i_init = 0;
    repeat (20) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midinit_busy", busy, 0);
    chk("midinit_rd_valid", rd_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i <= 20; i++) xfer(0, 6'(i), 8'h0);
    xfer(0, 6'd30, 8'h0);
    idle(3);
    chk("sb_empty_midinit", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion");
    $fatal(1, "watchdog");
  end
endmodule
